// File: rtl/stopwatch_core.sv
// Stopwatch/countdown engine with debounced run/clear/lap keys, feeding a six-digit display path.
// Latency: a key press acts DEB_MAX+2 clocks after it is first sampled low; data/state outputs are registered.
// Backpressure: none; the display consumes data/point/seg_en/sign every cycle. Optional lap: `STOPWATCH_LAP_EN.

// Per-key debouncer: raw must disagree with the debounced level for DEB_MAX+1 clocks before it is taken.
module stopwatch_debounce #(
    parameter int               DEB_W   = 16,
    parameter logic [DEB_W-1:0] DEB_MAX = 16'd49_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key,
    output logic key_ev
);
    logic [DEB_W-1:0] deb_cnt;
    logic             key_db;
    logic             key_db_prev;

    // Count disagreement length; commit the raw level once it has persisted long enough.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            deb_cnt     <= '0;
            key_db      <= 1'b1;
            key_db_prev <= 1'b1;
        end else begin
            key_db_prev <= key_db;
            if (key != key_db) begin
                if (deb_cnt == DEB_MAX) begin
                    key_db  <= key;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Keys are active-low: a debounced falling edge is the press event (one clock wide).
    assign key_ev = key_db_prev & ~key_db;
endmodule

module stopwatch_core #(
    parameter logic [18:0] CNT_MAX  = 19'd499_999,
    parameter int          CNT_W    = 19,
    parameter int          DATA_W   = 20,
    parameter logic [19:0] DATA_MAX = 20'd999_999,
    parameter logic [15:0] DEB_MAX  = 16'd49_999,
    parameter int          DEB_W    = 16,
    parameter logic [5:0]  POINT    = 6'b000_100
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              key_run,
    input  logic              key_clr,
    input  logic              key_lap,
    input  logic              mode_down,
    input  logic [DATA_W-1:0] preset,
    output logic [DATA_W-1:0] data,
    output logic [5:0]        point,
    output logic              seg_en,
    output logic              sign,
    output logic              running,
    output logic              expired,
    output logic              lap_hold
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  psc_q, psc_d;
    logic [DATA_W-1:0] cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic              seg_en_q;
    logic [DATA_W-1:0] lap_q;
    logic              lap_hold_q;
    logic              run_ev, clr_ev, lap_ev;
    logic              tick;
    logic [DATA_W-1:0] preset_sat;

    stopwatch_debounce #(.DEB_W(DEB_W), .DEB_MAX(DEB_MAX[DEB_W-1:0])) u_deb_run (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key_run), .key_ev(run_ev));
    stopwatch_debounce #(.DEB_W(DEB_W), .DEB_MAX(DEB_MAX[DEB_W-1:0])) u_deb_clr (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key_clr), .key_ev(clr_ev));

    assign tick       = (state_q == S_RUN) && (psc_q == CNT_MAX[CNT_W-1:0]);
    assign preset_sat = (preset > DATA_MAX[DATA_W-1:0]) ? DATA_MAX[DATA_W-1:0] : preset;

    // Next state: clear beats everything (including a coincident tick), then run events, then count ticks.
    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        if (clr_ev) begin
            state_d = S_IDLE;
            psc_d   = '0;
            mode_d  = mode_down;
            cnt_d   = mode_down ? preset_sat : '0;
        end else begin
            if (state_q == S_RUN)
                psc_d = tick ? '0 : psc_q + 1'b1;
            if (run_ev) begin
                case (state_q)
                    S_IDLE:  if (!(mode_q && cnt_q == '0)) state_d = S_RUN;
                    S_RUN:   state_d = S_PAUSE;
                    S_PAUSE: state_d = S_RUN;
                    default: state_d = state_q;
                endcase
            end
            if (tick) begin
                if (!mode_q) begin
                    cnt_d = (cnt_q == DATA_MAX[DATA_W-1:0]) ? '0 : cnt_q + 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                    // Expiry wins over a pause requested on the same edge.
                    if (cnt_q == DATA_W'(1)) state_d = S_DONE;
                end
            end
        end
    end

    // Core state registers; seg_en rises on the first edge after reset release.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_IDLE;
            psc_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            seg_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            psc_q    <= psc_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            seg_en_q <= 1'b1;
        end
    end

`ifdef STOPWATCH_LAP_EN
    stopwatch_debounce #(.DEB_W(DEB_W), .DEB_MAX(DEB_MAX[DEB_W-1:0])) u_deb_lap (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key(key_lap), .key_ev(lap_ev));

    // Lap toggles a frozen snapshot while running; a same-cycle clear or run event takes precedence.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lap_q      <= '0;
            lap_hold_q <= 1'b0;
        end else if (clr_ev) begin
            lap_hold_q <= 1'b0;
        end else if (lap_ev && !run_ev && state_q == S_RUN) begin
            if (!lap_hold_q) begin
                lap_q      <= cnt_q;
                lap_hold_q <= 1'b1;
            end else begin
                lap_hold_q <= 1'b0;
            end
        end
    end
`else
    logic unused_lap;
    assign unused_lap = key_lap;
    assign lap_ev     = 1'b0;
    assign lap_q      = '0;
    assign lap_hold_q = 1'b0;
`endif

    assign data     = lap_hold_q ? lap_q : cnt_q;
    assign point    = POINT;
    assign sign     = 1'b0;
    assign seg_en   = seg_en_q;
    assign running  = (state_q == S_RUN);
    assign expired  = (state_q == S_DONE);
    assign lap_hold = lap_hold_q;
endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;
    localparam int CMAX = 9;
    localparam int DMAX = 99;
    localparam int DEBM = 3;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    logic        sys_clk = 1'b1;
    logic        sys_rst_n;
    logic        key_run, key_clr, key_lap, mode_down;
    logic [19:0] preset;
    logic [19:0] data;
    logic [5:0]  point;
    logic        seg_en, sign, running, expired, lap_hold;

    always #5 sys_clk = ~sys_clk;

    stopwatch_core #(
        .CNT_MAX(19'd9), .CNT_W(19), .DATA_W(20), .DATA_MAX(20'd99),
        .DEB_MAX(16'd3), .DEB_W(16), .POINT(6'b000_100)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_run(key_run), .key_clr(key_clr),
        .key_lap(key_lap), .mode_down(mode_down), .preset(preset), .data(data),
        .point(point), .seg_en(seg_en), .sign(sign), .running(running),
        .expired(expired), .lap_hold(lap_hold)
    );

    typedef struct packed {
        logic [19:0] data;
        logic [5:0]  point;
        logic        seg_en;
        logic        sign;
        logic        running;
        logic        expired;
        logic        lap_hold;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_exp, mon_act;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   s_run = -1, s_clr = -1, s_lap = -1;

    // Behavioural model: stopwatch as flags plus elapsed-clock arithmetic.
    bit m_seg, m_run, m_pause, m_done, m_down, m_hold;
    int m_count, m_phase, m_lap;

    function automatic obs_t expected();
        obs_t e;
        e.data     = 20'(m_hold ? m_lap : m_count);
        e.point    = 6'b000_100;
        e.seg_en   = m_seg;
        e.sign     = 1'b0;
        e.running  = m_run;
        e.expired  = m_done;
        e.lap_hold = m_hold;
        return e;
    endfunction

    task automatic check_now(input logic [23:0] act, input logic [23:0] req, input string what);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t got=%h required=%h", what, $time, act, req);
        end
    endtask

    task automatic model_reset();
        m_seg = 0; m_run = 0; m_pause = 0; m_done = 0; m_down = 0; m_hold = 0;
        m_count = 0; m_phase = 0; m_lap = 0;
        s_run = -1; s_clr = -1; s_lap = -1;
    endtask

    task automatic model_step();
        bit ev_run, ev_clr, ev_lap, was_run;
        int old_count;
        ev_run = (cyc == s_run);
        ev_clr = (cyc == s_clr);
        ev_lap = (cyc == s_lap) && LAP_ON;
        m_seg  = 1;
        if (ev_clr) begin
            m_down  = mode_down;
            m_count = mode_down ? ((int'(preset) > DMAX) ? DMAX : int'(preset)) : 0;
            m_run = 0; m_pause = 0; m_done = 0; m_phase = 0; m_hold = 0;
            return;
        end
        was_run   = m_run;
        old_count = m_count;
        if (was_run) begin
            m_phase++;
            if (m_phase == CMAX + 1) begin
                m_phase = 0;
                if (!m_down) m_count = (m_count + 1) % (DMAX + 1);
                else if (m_count > 0) begin
                    m_count--;
                    if (m_count == 0) begin m_done = 1; m_run = 0; end
                end
            end
        end
        if (ev_run) begin
            if (was_run) begin
                if (!m_done) begin m_run = 0; m_pause = 1; end
            end else if (m_pause) begin
                m_pause = 0; m_run = 1;
            end else if (!m_done) begin
                if (!(m_down && old_count == 0)) m_run = 1;
            end
        end else if (ev_lap && was_run) begin
            if (!m_hold) begin m_lap = old_count; m_hold = 1; end
            else m_hold = 0;
        end
    endtask

    // One clock: publish the expectation for this interval, advance the model on the edge.
    task automatic cycle();
        exp_q.push_back(expected());
        @(posedge sys_clk);
        cyc++;
        if (sys_rst_n) model_step();
        #1;
    endtask

    task automatic wait_n(input int n);
        repeat (n) cycle();
    endtask

    // which: 0 run, 1 clear, 2 lap, 3 clear+run together.
    task automatic press(input int which, input int extra);
        int eff;
        eff = cyc + DEBM + 2;
        if (which == 0 || which == 3) begin key_run = 0; s_run = eff; end
        if (which == 1 || which == 3) begin key_clr = 0; s_clr = eff; end
        if (which == 2) begin key_lap = 0; s_lap = eff; end
        wait_n(DEBM + 1 + extra);
        key_run = 1; key_clr = 1; key_lap = 1;
        wait_n(DEBM + 3);
    endtask

    task automatic glitch();
        key_run = 0;
        wait_n(DEBM);
        key_run = 1;
        wait_n(DEBM + 3);
    endtask

    task automatic clr_cfg(input bit down, input int pre);
        mode_down = down;
        preset    = 20'(pre);
        press(1, 0);
    endtask

    task automatic do_reset();
        sys_rst_n = 0;
        #1;
        check_now({data, seg_en, running, expired, lap_hold}, 24'h0, "reset outputs");
        model_reset();
        wait_n(2);
        sys_rst_n = 1;
        wait_n(1);
    endtask

    // Monitor: compare every displayed cycle against the queued expectation.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (exp_q.size() > 0) begin
                mon_exp = exp_q.pop_front();
                mon_act = {data, point, seg_en, sign, running, expired, lap_hold};
                total++;
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("FAIL outputs t=%0t got data=%0d pt=%b seg=%b sgn=%b run=%b exp=%b hold=%b required data=%0d pt=%b seg=%b sgn=%b run=%b exp=%b hold=%b",
                             $time, mon_act.data, mon_act.point, mon_act.seg_en, mon_act.sign,
                             mon_act.running, mon_act.expired, mon_act.lap_hold,
                             mon_exp.data, mon_exp.point, mon_exp.seg_en, mon_exp.sign,
                             mon_exp.running, mon_exp.expired, mon_exp.lap_hold);
                end
            end
        end
    end

    initial begin
        int r;
        sys_rst_n = 0; key_run = 1; key_clr = 1; key_lap = 1;
        mode_down = 0; preset = '0;
        model_reset();
        #1;
        check_now({data, seg_en, running, expired, lap_hold}, 24'h0, "initial reset outputs");
        wait_n(2);
        sys_rst_n = 1;
        wait_n(1);

        // Start, glitch, pause/resume, then run long enough to wrap 99 -> 0.
        press(0, 0);
        wait_n(55);
        glitch();
        press(0, 1);
        wait_n(20);
        press(0, 0);
        wait_n(1000);

        // Lap freeze, release, and a lap press while paused.
        press(2, 0);
        wait_n(60);
        press(2, 0);
        press(0, 0);
        press(2, 0);
        press(0, 0);
        wait_n(15);

        // Clear and run in the same cycle.
        press(3, 0);
        wait_n(5);

        // Countdown to expiry, ignored run, preset ceiling.
        clr_cfg(1, 3);
        press(0, 0);
        wait_n(40);
        check_now({data, running, expired, 1'b0}, {20'd0, 1'b0, 1'b1, 1'b0}, "expired after countdown");
        press(0, 0);
        clr_cfg(1, 150);
        wait_n(5);

        // Reset in the middle of an up count.
        clr_cfg(0, 0);
        press(0, 0);
        wait_n(13);
        do_reset();

        for (int i = 0; i < 90; i++) begin
            r = $urandom_range(0, 10);
            case (r)
                0, 1, 2: press(0, $urandom_range(0, 2));
                3:       clr_cfg(1'($urandom_range(0, 1)), $urandom_range(0, 160));
                4, 5:    press(2, $urandom_range(0, 2));
                6:       glitch();
                7:       wait_n($urandom_range(1, 60));
                8:       press(3, 0);
                9:       wait_n($urandom_range(100, 250));
                default: if ($urandom_range(0, 3) == 0) do_reset(); else wait_n(7);
            endcase
        end

        wait_n(3);
        #10;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
